// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   iter_cnt;
    logic [2:0]      op;
    logic [4:0]      rd_lat;
    logic [31:0]     a_lat;
    logic [31:0]     opnd;
    logic [63:0]     acc;
    logic            neg_a;
    logic            neg_b;
    logic            b_zero;

    logic            accept;
    logic            signed_a;
    logic            signed_b;
    logic            in_neg_a;
    logic            in_neg_b;
    logic [31:0]     mag_a;
    logic [31:0]     mag_b;
    logic [32:0]     mul_sum;
    logic [63:0]     mul_next;
    logic [32:0]     rem_sh;
    logic [32:0]     div_diff;
    logic [63:0]     div_next;
    logic [63:0]     prod;
    logic [31:0]     quo;
    logic [31:0]     rem;
    logic [31:0]     fix_res;

    assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
    assign busy     = (state == S_CALC) || (state == S_FIX);
    assign done     = (state == S_DONE);

    // rs1 is unsigned only for MULHU/DIVU/REMU; rs2 is also unsigned for MULHSU
    assign signed_a = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    assign signed_b = signed_a && (funct3 != 3'b010);
    assign in_neg_a = signed_a && op_a[31];
    assign in_neg_b = signed_b && op_b[31];
    assign mag_a    = in_neg_a ? (32'd0 - op_a) : op_a;
    assign mag_b    = in_neg_b ? (32'd0 - op_b) : op_b;

    // Multiply: acc holds {partial product, remaining multiplier bits}, shifted right each step
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // Divide: acc holds {remainder, dividend bits turning into quotient bits}
    assign rem_sh   = acc[63:31];
    assign div_diff = rem_sh - {1'b0, opnd};
    assign div_next = div_diff[32] ? {rem_sh[31:0], acc[30:0], 1'b0}
                                   : {div_diff[31:0], acc[30:0], 1'b1};

    assign prod = (neg_a ^ neg_b) ? (64'd0 - acc) : acc;
    assign quo  = acc[31:0];
    assign rem  = acc[63:32];

    always_comb begin
        fix_res = 32'd0;
        case (op)
            3'b000:                 fix_res = prod[31:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[63:32];
            3'b100, 3'b101: begin
                if (b_zero)
                    fix_res = 32'hFFFF_FFFF;
                else
                    fix_res = (neg_a ^ neg_b) ? (32'd0 - quo) : quo;
            end
            default: begin
                if (b_zero)
                    fix_res = a_lat;
                else
                    fix_res = neg_a ? (32'd0 - rem) : rem;
            end
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = S_CALC;
            S_CALC: if (iter_cnt == CW'(ITER - 1)) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            S_DONE: state_next = accept ? S_CALC : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iter_cnt <= '0;
            op       <= 3'd0;
            rd_lat   <= 5'd0;
            a_lat    <= 32'd0;
            opnd     <= 32'd0;
            acc      <= 64'd0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            b_zero   <= 1'b0;
            result   <= '0;
            rd_out   <= 5'd0;
        end else if (accept) begin
            iter_cnt <= '0;
            op       <= funct3;
            rd_lat   <= rd_in;
            a_lat    <= op_a;
            neg_a    <= in_neg_a;
            neg_b    <= in_neg_b;
            b_zero   <= (op_b == 32'd0);
            if (funct3[2]) begin
                acc  <= {32'd0, mag_a};
                opnd <= mag_b;
            end else begin
                acc  <= {32'd0, mag_b};
                opnd <= mag_a;
            end
        end else if (state == S_CALC) begin
            iter_cnt <= iter_cnt + CW'(1);
            acc      <= op[2] ? div_next : mul_next;
        end else if (state == S_FIX) begin
            result   <= fix_res;
            rd_out   <= rd_lat;
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Sits between the register file read ports and its write port.
- Consumes rs1/rs2 read data plus the destination index.
- Produces the 32-bit writeback value, rd index and a one-cycle done strobe that drives the register file write_enable for M-extension instructions.

Parameters:
- XLEN, 32, operand/result width. The RTL only needs to support 32.
- ITER, 32, number of CALC iterations. Must equal XLEN.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (reset==0 resets immediately)
- start  input  1  request; accepted only in IDLE or DONE
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  32  rs1 value
- op_b  input  32  rs2 value
- rd_in  input  5  destination register index
- busy  output  1  high in CALC and FIX
- done  output  1  one-cycle pulse; result/rd_out valid
- result  output  32  writeback data
- rd_out  output  5  destination index for the write port

Behaviour:
- Reset (reset==0, async):
  - State→IDLE.
  - busy=0, done=0, result=0, rd_out=0.
  - Internal accumulators cleared.
  - Asserting reset mid-operation aborts the operation; no done is ever produced for it.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On a clk edge with start=1: latch funct3, op_a, op_b and rd_in; enter CALC with iteration count 0.
  - Operand changes after acceptance have no effect.
- CALC: one iteration per cycle for ITER cycles, then FIX.
  - Multiply: shift-add on operand magnitudes into a 64-bit product.
    - MUL/MULH: both operands signed.
    - MULHSU: op_a signed, op_b unsigned.
    - MULHU: both operands unsigned.
  - Divide: restoring division on magnitudes, one quotient bit per cycle.
    - DIV/REM: signed.
    - DIVU/REMU: unsigned.
- FIX (1 cycle): sign correction and result selection.
  - MUL: low 32 bits of the product.
  - MULH*: high 32 bits of the two's-complement product.
  - DIV quotient sign = sign(a) XOR sign(b).
  - REM sign = sign(a).
  - Divide by zero: quotient=0xFFFFFFFF (DIV and DIVU); remainder=op_a.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient=0x80000000, remainder=0.
  - Special cases take the full fixed latency; no early exit.
  - Register result and rd_out; enter DONE.
- DONE: done=1 for exactly this cycle.
  - result and rd_out hold their values after DONE until the next FIX.
  - start=1 in DONE is accepted (back-to-back issue) and goes directly to CALC.
  - Otherwise go to IDLE.
- Latency: start accepted at edge E0.
  - busy=1 after E0.
  - done=1 in the cycle after edge E0+ITER+1 (34 cycles from accept to done visible, ITER=32).
  - busy=0 while done=1.
- start while busy: ignored, with no side effects. The consumer must hold the request until it observes busy=0.
- funct3 is sampled only at acceptance.
- All arithmetic is modulo 2^32 on outputs; intermediates are 64-bit (multiply) or 33-bit remainder (divide).

Test Plan:
- Reset low for 2 cycles then high, with start=0 → busy=0, done=0, result=0, rd_out=0. Then MUL 7×0xFFFFFFFD, rd_in=5 → done pulses one cycle exactly 34 cycles after accept; result=0xFFFFFFEB, rd_out=5.
- Multiply high variants:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Signed and unsigned divide:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM same operands → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14; REMU → 2.
- Edge cases:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - Each completes in 34 cycles.
- Handshake:
  - Toggle op_a and pulse start during CALC → ignored; result reflects latched operands.
  - Assert start in the DONE cycle with new operands → second done 34 cycles later with the second result.
- Drop reset to 0 at iteration 10 of a DIV → busy=0, outputs=0 immediately (asynchronous). After release, no done occurs until a new start.
